reset_sequencer: RTL

Consumes the single-cycle rising-edge pulse from the reset-button debouncer, plus PLL lock status and a CPU soft-reset request. Generates staged, registered, active-high resets: peripherals are released first, the CPU after a fixed gap. Records the cause of the last reset for software readback. Sits in the reset subsystem, directly downstream of the button debouncer.

---
 rtl/reset_sequencer_if.sv | 18 +
 rtl/reset_sequencer.sv | 85 ++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: trigger inputs and staged reset outputs of the reset sequencer
interface reset_sequencer_if;
  logic       iButtonPulse;
  logic       iSoftReset;
  logic       iPllLocked;
  logic       oPeriphReset;
  logic       oCpuReset;
  logic       oResetDone;
  logic [1:0] oResetCause;
  modport master (
    output iButtonPulse, iSoftReset, iPllLocked,
    input  oPeriphReset, oCpuReset, oResetDone, oResetCause
  );
  modport slave (
    input  iButtonPulse, iSoftReset, iPllLocked,
    output oPeriphReset, oCpuReset, oResetDone, oResetCause
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged peripheral/CPU reset release with sticky reset-cause record
module reset_sequencer #(
  parameter int                     pTimerWidth = 16,
  parameter logic [pTimerWidth-1:0] pHoldCycles = 16'd50_000,
  parameter logic [pTimerWidth-1:0] pStageGap   = 16'd5_000
) (
  input logic              gClock,
  input logic              gReset,
  reset_sequencer_if.slave bus
);
  typedef enum logic [1:0] {HOLD, REL_PERIPH, RUN} state_t;
  localparam logic [pTimerWidth-1:0] ONE     = {{(pTimerWidth-1){1'b0}}, 1'b1};
  localparam logic [pTimerWidth-1:0] HOLD_LD = pHoldCycles - ONE;
  localparam logic [pTimerWidth-1:0] GAP_LD  = pStageGap - ONE;
  state_t                 r_state, w_state;
  logic [pTimerWidth-1:0] r_timer, w_timer;
  logic                   r_periph, w_periph;
  logic                   r_cpu, w_cpu;
  logic                   r_done, w_done;
  logic [1:0]             r_cause, w_cause;
  logic                   w_req, w_pll_loss, w_zero;
  assign w_req      = bus.iButtonPulse | bus.iSoftReset;
  assign w_pll_loss = ~bus.iPllLocked;
  assign w_zero     = (r_timer == '0);
  always_ff @(posedge gClock) begin
    if (gReset) begin
      r_state  <= HOLD;
      r_timer  <= HOLD_LD;
      r_periph <= 1'b1;
      r_cpu    <= 1'b1;
      r_done   <= 1'b0;
      r_cause  <= 2'b00;
    end else begin
      r_state  <= w_state;
      r_timer  <= w_timer;
      r_periph <= w_periph;
      r_cpu    <= w_cpu;
      r_done   <= w_done;
      r_cause  <= w_cause;
    end
  end
  // A trigger always beats timer expiry on the same edge
  always_comb begin
    w_state  = r_state;
    w_timer  = r_timer;
    w_periph = r_periph;
    w_cpu    = r_cpu;
    w_done   = 1'b0;
    w_cause  = r_cause;
    if (r_state == HOLD) begin
      w_periph = 1'b1;
      w_cpu    = 1'b1;
      if (w_pll_loss) begin
        w_timer = HOLD_LD;
      end else if (w_req) begin
        w_timer = HOLD_LD;
        w_cause = bus.iButtonPulse ? 2'b01 : 2'b10;
      end else if (w_zero) begin
        w_state  = REL_PERIPH;
        w_timer  = GAP_LD;
        w_periph = 1'b0;
      end else begin
        w_timer = r_timer - ONE;
      end
    end else if (w_req | w_pll_loss) begin
      w_state  = HOLD;
      w_timer  = HOLD_LD;
      w_periph = 1'b1;
      w_cpu    = 1'b1;
      w_cause  = w_pll_loss ? 2'b11 : bus.iButtonPulse ? 2'b01 : 2'b10;
    end else if (r_state == REL_PERIPH) begin
      if (w_zero) begin
        w_state = RUN;
        w_cpu   = 1'b0;
        w_done  = 1'b1;
      end else begin
        w_timer = r_timer - ONE;
      end
    end
  end
  assign bus.oPeriphReset = r_periph;
  assign bus.oCpuReset    = r_cpu;
  assign bus.oResetDone   = r_done;
  assign bus.oResetCause  = r_cause;
endmodule
